// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver: configurable width, parity and stop bits, majority-vote sampling,
// false-start rejection and a valid/ready holding register with overrun detection.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int unsigned CyclesPerTick = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CycW = (CyclesPerTick > 1) ? $clog2(CyclesPerTick) : 1;
  localparam int unsigned IdxW = $clog2(OVERSAMPLE);
  localparam int unsigned Mid  = OVERSAMPLE / 2;

  localparam logic [CycW-1:0] CycLast = CycW'(CyclesPerTick - 1);
  localparam logic [IdxW-1:0] IdxPre  = IdxW'(Mid - 1);
  localparam logic [IdxW-1:0] IdxMid  = IdxW'(Mid);
  localparam logic [IdxW-1:0] IdxDec  = IdxW'(Mid + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(OVERSAMPLE - 1);
  localparam logic [3:0]      DataLast = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

  if (CyclesPerTick < 1) begin : g_bad_tick
    $error("uart_rx_cfg: CLK_FREQ / (BAUD_RATE*OVERSAMPLE) must be >= 1");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_cfg: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
    $error("uart_rx_cfg: DATA_WIDTH must be 5..9");
  end
  if (PARITY_MODE > 2) begin : g_bad_par
    $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic                  rxd_meta_q, rxd_s_q;
  logic [1:0]            prime_q, prime_d;
  logic                  armed_q, armed_d;
  logic [CycW-1:0]       cyc_q, cyc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  s_pre_q, s_pre_d, s_mid_q, s_mid_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  ferr_q, ferr_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;

  logic tick, dec, bit_end, maj, consume, par_xor, par_bad;

  assign tick    = (cyc_q == CycLast);
  assign dec     = tick && (idx_q == IdxDec);
  assign bit_end = tick && (idx_q == IdxLast);
  assign maj     = (s_pre_q & s_mid_q) | (s_pre_q & rxd_s_q) | (s_mid_q & rxd_s_q);
  assign consume = rx_valid_q && rx_ready;
  assign par_xor = (^shift_q) ^ par_bit_q;
  assign par_bad = (PARITY_MODE == 1) ? par_xor :
                   (PARITY_MODE == 2) ? ~par_xor : 1'b0;

  always_comb begin
    state_d   = state_q;
    prime_d   = {prime_q[0], 1'b1};
    armed_d   = armed_q;
    cyc_d     = tick ? '0 : cyc_q + 1'b1;
    idx_d     = idx_q;
    s_pre_d   = s_pre_q;
    s_mid_d   = s_mid_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;

    if (tick) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      if (idx_q == IdxPre) s_pre_d = rxd_s_q;
      if (idx_q == IdxMid) s_mid_d = rxd_s_q;
    end

    unique case (state_q)
      StIdle: begin
        // prime_q keeps the preset synchroniser value from arming straight out of reset
        if (rxd_s_q && prime_q[1]) armed_d = 1'b1;
        if (armed_q && !rxd_s_q) begin
          state_d   = StStart;
          armed_d   = 1'b0;
          ferr_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (dec && maj) begin
          state_d = StIdle;
        end else if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (dec) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == DataLast) begin
            state_d   = (PARITY_MODE != 0) ? StParity : StStop;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (dec) par_bit_d = maj;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (dec) begin
          if (!maj) ferr_d = 1'b1;
          // leave on the last decision tick so an immediately following start edge is seen
          if (bit_cnt_q == StopLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        if (bit_end) bit_cnt_d = bit_cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q || state_q == StIdle) begin
      cyc_d = '0;
      idx_d = '0;
    end
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = rx_valid_q && !consume;
    overrun_d    = 1'b0;
    if (done_q) begin
      if (!rx_valid_q || consume) begin
        rx_data_d    = shift_q;
        parity_err_d = par_bad;
        frame_err_d  = ferr_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      prime_q      <= '0;
      armed_q      <= 1'b0;
      cyc_q        <= '0;
      idx_q        <= '0;
      s_pre_q      <= 1'b1;
      s_mid_q      <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rxd_meta_q   <= rxd;
      rxd_s_q      <= rxd_meta_q;
      prime_q      <= prime_d;
      armed_q      <= armed_d;
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      s_pre_q      <= s_pre_d;
      s_mid_q      <= s_mid_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      ferr_q       <= ferr_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances share one serial line (even/1-stop, odd/1-stop,
// 7-bit/no-parity/2-stop); frames are sent bit by bit and results checked against constants.
module tb_uart_rx_cfg;

  localparam int BitCyc = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_ab = 1'b1, reset_c = 1'b1, line = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic valid_b, perr_b, ferr_b, ovr_b, busy_b;
  logic valid_c, perr_c, ferr_c, ovr_c, busy_c;

  uart_rx_cfg #(.CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_WIDTH(8),
                .PARITY_MODE(1), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset_ab), .rxd(line), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a),
    .busy(busy_a));

  uart_rx_cfg #(.CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_WIDTH(8),
                .PARITY_MODE(2), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset_ab), .rxd(line), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b),
    .busy(busy_b));

  uart_rx_cfg #(.CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_WIDTH(7),
                .PARITY_MODE(0), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset_c), .rxd(line), .rx_data(data_c), .rx_valid(valid_c),
    .rx_ready(ready_c), .parity_err(perr_c), .frame_err(ferr_c), .overrun_err(ovr_c),
    .busy(busy_c));

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Transfer monitors, sampled on the falling edge away from DUT updates.
  int fa_cnt = 0, fb_cnt = 0, fc_cnt = 0, ov_a = 0, vhi_a = 0;
  logic [7:0] fa_data = '0;
  logic [6:0] fc_data = '0;
  logic fa_perr = 1'b0, fa_ferr = 1'b0, fb_perr = 1'b0, fc_ferr = 1'b0;

  always @(negedge clk) begin
    if (!reset_ab) begin
      if (valid_a) vhi_a <= vhi_a + 1;
      if (ovr_a) ov_a <= ov_a + 1;
      if (valid_a && ready_a) begin
        fa_cnt <= fa_cnt + 1; fa_data <= data_a; fa_perr <= perr_a; fa_ferr <= ferr_a;
      end
      if (valid_b && ready_b) begin
        fb_cnt <= fb_cnt + 1; fb_perr <= perr_b;
      end
    end
    if (!reset_c && valid_c && ready_c) begin
      fc_cnt <= fc_cnt + 1; fc_data <= data_c; fc_ferr <= ferr_c;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // glitch_bit: data bit index that gets a 1-cycle inversion at its centre sample, -1 for none
  task automatic send(input logic [8:0] data, input int nd, input bit has_par, input logic par,
                      input int ns, input logic stop_v, input int glitch_bit);
    line = 1'b0;
    cyc(BitCyc);
    for (int i = 0; i < nd; i++) begin
      line = data[i];
      if (i == glitch_bit) begin
        cyc(18);
        line = ~data[i];
        cyc(1);
        line = data[i];
        cyc(13);
      end else begin
        cyc(BitCyc);
      end
    end
    if (has_par) begin
      line = par;
      cyc(BitCyc);
    end
    for (int i = 0; i < ns; i++) begin
      line = stop_v;
      cyc(BitCyc);
    end
    line = 1'b1;
  endtask

  int base, base2, base_ov, base_v;

  initial begin
    cyc(4);
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_data", data_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_errs", {perr_a, ferr_a, ovr_a}, 0);
    check_eq("rst_c_all", {valid_c, data_c, perr_c, ferr_c, ovr_c, busy_c}, 0);
    reset_ab = 1'b0;
    reset_c  = 1'b0;
    cyc(40);

    // 0xA5, even parity bit 0
    base = fa_cnt; base_v = vhi_a;
    send(9'h0A5, 8, 1, 1'b0, 1, 1'b1, -1);
    cyc(8);
    check_eq("a5_count", fa_cnt - base, 1);
    check_eq("a5_data", fa_data, 8'hA5);
    check_eq("a5_errs", {fa_perr, fa_ferr}, 0);
    check_eq("a5_valid_cycles", vhi_a - base_v, 1);

    // 0x3C with parity bit 1: wrong for even, right for odd
    base = fb_cnt;
    send(9'h03C, 8, 1, 1'b1, 1, 1'b1, -1);
    cyc(8);
    check_eq("3c_data", fa_data, 8'h3C);
    check_eq("3c_even_perr", fa_perr, 1);
    check_eq("3c_odd_count", fb_cnt - base, 1);
    check_eq("3c_odd_perr", fb_perr, 0);

    // 8-cycle low glitch on idle line
    base = fa_cnt;
    line = 1'b0;
    cyc(6);
    check_eq("glitch_busy_hi", busy_a, 1);
    cyc(2);
    line = 1'b1;
    cyc(BitCyc);
    check_eq("glitch_busy_lo", busy_a, 0);
    check_eq("glitch_no_frame", fa_cnt - base, 0);
    cyc(16);

    // 0x00 with a high glitch at the centre sample of data bit 3
    send(9'h000, 8, 1, 1'b0, 1, 1'b1, 3);
    cyc(8);
    check_eq("vote_data", fa_data, 8'h00);
    check_eq("vote_perr", fa_perr, 0);

    // overrun: consumer stalled, two frames back-to-back
    ready_a = 1'b0;
    base = fa_cnt; base_ov = ov_a;
    send(9'h011, 8, 1, 1'b0, 1, 1'b1, -1);
    send(9'h022, 8, 1, 1'b0, 1, 1'b1, -1);
    cyc(8);
    check_eq("ovr_pulses", ov_a - base_ov, 1);
    check_eq("ovr_valid_held", valid_a, 1);
    check_eq("ovr_data_held", data_a, 8'h11);
    check_eq("ovr_no_xfer", fa_cnt - base, 0);
    ready_a = 1'b1;
    cyc(4);
    check_eq("ovr_xfer", fa_cnt - base, 1);
    check_eq("ovr_xfer_data", fa_data, 8'h11);
    check_eq("ovr_valid_drop", valid_a, 0);
    cyc(16);

    // stop bit low
    send(9'h055, 8, 1, 1'b0, 1, 1'b0, -1);
    cyc(16);
    check_eq("stop_data", fa_data, 8'h55);
    check_eq("stop_ferr", fa_ferr, 1);
    cyc(32);

    // break: line low for 20 bit times
    base = fa_cnt;
    line = 1'b0;
    cyc(15 * BitCyc);
    check_eq("brk_idle_low", busy_a, 0);
    cyc(5 * BitCyc);
    check_eq("brk_one_frame", fa_cnt - base, 1);
    check_eq("brk_data", fa_data, 8'h00);
    check_eq("brk_errs", {fa_perr, fa_ferr}, 2'b01);
    line = 1'b1;
    cyc(3 * BitCyc);
    check_eq("brk_no_more", fa_cnt - base, 1);

    // 7-bit, no parity, 2 stop bits
    reset_c = 1'b1;
    cyc(2);
    reset_c = 1'b0;
    cyc(40);
    ready_c = 1'b0;
    send(9'h07F, 7, 0, 1'b0, 2, 1'b1, -1);
    cyc(8);
    check_eq("c7f_valid", valid_c, 1);
    check_eq("c7f_data", data_c, 7'h7F);
    check_eq("c7f_ferr", ferr_c, 0);

    // reset in the middle of the next frame while the line is low
    line = 1'b0;
    cyc(48);
    reset_c = 1'b1;
    cyc(1);
    reset_c = 1'b0;
    check_eq("crst_outs", {valid_c, data_c, perr_c, ferr_c, ovr_c, busy_c}, 0);
    base2 = fc_cnt;
    cyc(2 * BitCyc);
    check_eq("crst_low_not_start", busy_c, 0);
    line = 1'b1;
    cyc(2 * BitCyc);
    check_eq("crst_no_frame", fc_cnt - base2, 0);
    ready_c = 1'b1;
    send(9'h001, 7, 0, 1'b0, 2, 1'b1, -1);
    cyc(8);
    check_eq("c01_count", fc_cnt - base2, 1);
    check_eq("c01_data", fc_data, 7'h01);
    check_eq("c01_ferr", fc_ferr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
